// File: rtl/mrv1_wb_arb.sv
// Write-back arbiter: per-FU one-entry holding slots feeding a single registered
// valid/ready write-back port through a round-robin pick.
module mrv1_wb_arb #(
  parameter int NUM_FU_P      = 4,
  parameter int DATA_WIDTH_P  = 32,
  parameter int ITAG_WIDTH_P  = 3,
  parameter int NUM_THREADS_P = 8,
  localparam int TID_WIDTH_LP    = $clog2(NUM_THREADS_P),
  localparam int FU_IDX_WIDTH_LP = $clog2(NUM_FU_P)
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [NUM_FU_P-1:0]                        fu_done_i,
  input  logic [NUM_FU_P-1:0][DATA_WIDTH_P-1:0]      fu_res_data_i,
  input  logic [NUM_FU_P-1:0][ITAG_WIDTH_P-1:0]      fu_itag_i,
  input  logic [NUM_FU_P-1:0][TID_WIDTH_LP-1:0]      fu_tid_i,
  output logic [NUM_FU_P-1:0]                        fu_stall_o,
  output logic                                       wb_vld_o,
  input  logic                                       wb_rdy_i,
  output logic [DATA_WIDTH_P-1:0]                    wb_data_o,
  output logic [ITAG_WIDTH_P-1:0]                    wb_itag_o,
  output logic [TID_WIDTH_LP-1:0]                    wb_tid_o,
  output logic [FU_IDX_WIDTH_LP-1:0]                 wb_fu_o,
  output logic                                       err_o
);

  // Handshake: a transfer completes on any cycle with wb_vld_o & wb_rdy_i; while
  // wb_vld_o=1 and wb_rdy_i=0 every wb_* output holds its value.

  logic [NUM_FU_P-1:0]        hold_vld;
  logic [DATA_WIDTH_P-1:0]    hold_data [NUM_FU_P];
  logic [ITAG_WIDTH_P-1:0]    hold_itag [NUM_FU_P];
  logic [TID_WIDTH_LP-1:0]    hold_tid  [NUM_FU_P];

  logic [FU_IDX_WIDTH_LP-1:0] rr_ptr;
  logic [FU_IDX_WIDTH_LP-1:0] sel;
  logic                       found;
  logic                       out_adv;
  logic [NUM_FU_P-1:0]        gnt;
  logic [NUM_FU_P-1:0]        capture;
  logic [NUM_FU_P-1:0]        violation;
  int                         cand;

  assign out_adv = ~wb_vld_o | wb_rdy_i;

  // Round-robin search: candidate j is rr_ptr+1+j wrapped once, so any
  // NUM_FU_P (power of two or not) works without a modulo operator.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = 0;
    for (int j = 0; j < NUM_FU_P; j++) begin
      cand = int'(rr_ptr) + 1 + j;
      if (cand >= NUM_FU_P) cand = cand - NUM_FU_P;
      for (int i = 0; i < NUM_FU_P; i++) begin
        if (!found && (cand == i) && hold_vld[i]) begin
          found = 1'b1;
          sel   = FU_IDX_WIDTH_LP'(i);
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NUM_FU_P; i++) begin
      gnt[i] = out_adv & found & (sel == FU_IDX_WIDTH_LP'(i));
    end
  end

  // A slot being granted this cycle can take a new result at the same edge.
  assign fu_stall_o = hold_vld & ~gnt;
  assign capture    = fu_done_i & ~fu_stall_o;
  assign violation  = fu_done_i & fu_stall_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_vld <= '0;
    end else begin
      for (int i = 0; i < NUM_FU_P; i++) begin
        if (capture[i]) begin
          hold_vld[i] <= 1'b1;
        end else if (gnt[i]) begin
          hold_vld[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_FU_P; i++) begin
      if (capture[i]) begin
        hold_data[i] <= fu_res_data_i[i];
        hold_itag[i] <= fu_itag_i[i];
        hold_tid[i]  <= fu_tid_i[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_vld_o  <= 1'b0;
      wb_data_o <= '0;
      wb_itag_o <= '0;
      wb_tid_o  <= '0;
      wb_fu_o   <= '0;
      rr_ptr    <= FU_IDX_WIDTH_LP'(NUM_FU_P - 1);
      err_o     <= 1'b0;
    end else begin
      if (out_adv) begin
        if (found) begin
          wb_vld_o  <= 1'b1;
          wb_data_o <= hold_data[sel];
          wb_itag_o <= hold_itag[sel];
          wb_tid_o  <= hold_tid[sel];
          wb_fu_o   <= sel;
          rr_ptr    <= sel;
        end else begin
          wb_vld_o  <= 1'b0;
        end
      end
      if (|violation) begin
        err_o <= 1'b1;
      end
    end
  end

  // A done pulse into a busy slot is dropped; flag it loudly in simulation.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (violation == '0)
        else $warning("mrv1_wb_arb: done pulse into busy slot dropped (fu mask %b)", violation);
    end
  end

endmodule
